// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// Module   : regfile_pkg
// Brief    : Shared types, defaults and address-width helper for regfile_mp.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

    typedef enum logic [0:0] {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_e;

    localparam int REGFILE_DW    = 32;
    localparam int REGFILE_DEPTH = 32;

    function automatic int regfile_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_clr_fsm.sv
//------------------------------------------------------------------------------
// Module   : regfile_clr_fsm
// Brief    : Clear sequencer; walks the sweep index 1..DEPTH-1 while busy.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = REGFILE_DEPTH
) (
    input  logic                         elk,
    input  logic                         nrst,
    input  logic                         clr_req,
    output logic                         busy,
    output logic [regfile_aw(DEPTH)-1:0] sweep_idx
);

    localparam int            AW        = regfile_aw(DEPTH);
    localparam logic [AW-1:0] IDX_FIRST = AW'(1);
    localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);

    clr_state_e    state_q, state_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        idx_d   = idx_q;
        case (state_q)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_d = CLR_SWEEP;
                    busy_d  = 1'b1;
                    idx_d   = IDX_FIRST;
                end
            end
            CLR_SWEEP: begin
                // Requests arriving mid-sweep are deliberately ignored.
                if (idx_q == IDX_LAST) begin
                    state_d = CLR_IDLE;
                    busy_d  = 1'b0;
                    idx_d   = IDX_FIRST;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = CLR_IDLE;
                busy_d  = 1'b0;
                idx_d   = IDX_FIRST;
            end
        endcase
    end

    always_ff @(posedge elk or posedge nrst) begin
        if (nrst) begin
            state_q <= CLR_IDLE;
            busy_q  <= 1'b0;
            idx_q   <= IDX_FIRST;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            idx_q   <= idx_d;
        end
    end

    assign busy      = busy_q;
    assign sweep_idx = idx_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
//------------------------------------------------------------------------------
// Module   : regfile_mp
// Brief    : Multi-read-port register file, registered reads, R0 hardwired to
//            zero, SP preset and sequenced clear. Optional write-first
//            forwarding when REGFILE_BYPASS_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int          DW      = REGFILE_DW,
    parameter int          DEPTH   = REGFILE_DEPTH,
    parameter int          NRD     = 2,
    parameter int          SP_IDX  = 29,
    parameter int unsigned SP_INIT = 252
) (
    input  logic                             elk,
    input  logic                             nrst,
    input  logic                             wr_en,
    input  logic [regfile_aw(DEPTH)-1:0]     wr_addr,
    input  logic [DW-1:0]                    wr_data,
    input  logic [NRD-1:0]                   rd_en,
    input  logic [NRD*regfile_aw(DEPTH)-1:0] rd_addr,
    output logic [NRD*DW-1:0]                rd_data,
    output logic [NRD-1:0]                   rd_valid,
    input  logic                             clr_req,
    output logic                             busy,
    output logic                             wr_err
);

    localparam int            AW      = regfile_aw(DEPTH);
    localparam logic [AW-1:0] SP_ADDR = AW'(SP_IDX);
    localparam logic [DW-1:0] SP_VAL  = DW'(SP_INIT);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          wr_err_q, wr_err_d;
    logic          w_busy;
    logic [AW-1:0] w_sweep_idx;
    logic          w_wr_acc;

    regfile_clr_fsm #(
        .DEPTH (DEPTH)
    ) u_clr_fsm (
        .elk       (elk),
        .nrst      (nrst),
        .clr_req   (clr_req),
        .busy      (w_busy),
        .sweep_idx (w_sweep_idx)
    );

    assign w_wr_acc = wr_en && !w_busy && (wr_addr != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_err_d = wr_en && (w_busy || (wr_addr == '0));
        if (w_busy) begin
            mem_d[w_sweep_idx] = (w_sweep_idx == SP_ADDR) ? SP_VAL : '0;
        end else if (w_wr_acc) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge elk or posedge nrst) begin
        if (nrst) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= (j == SP_IDX) ? SP_VAL : '0;
            end
            wr_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_err_q <= wr_err_d;
        end
    end

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [AW-1:0] w_addr;
            logic          w_fwd;
            logic [DW-1:0] data_q, data_d;
            logic          valid_q, valid_d;

            assign w_addr = rd_addr[i*AW +: AW];

`ifdef REGFILE_BYPASS_EN
            assign w_fwd = w_wr_acc && (wr_addr == w_addr);
`else
            assign w_fwd = 1'b0;
`endif

            always_comb begin
                data_d  = data_q;
                valid_d = 1'b0;
                if (rd_en[i] && !w_busy) begin
                    valid_d = 1'b1;
                    if (w_addr == '0) begin
                        data_d = '0;
                    end else if (w_fwd) begin
                        data_d = wr_data;
                    end else begin
                        data_d = mem_q[w_addr];
                    end
                end
            end

            always_ff @(posedge elk or posedge nrst) begin
                if (nrst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign rd_data[i*DW +: DW] = data_q;
            assign rd_valid[i]         = valid_q;
        end
    endgenerate

    assign busy   = w_busy;
    assign wr_err = wr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
//------------------------------------------------------------------------------
// Module   : tb_regfile_mp
// Brief    : Self-checking bench for regfile_mp (default 32x32, two read ports).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        elk;
    logic        nrst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic        clr_req;
    logic        busy;
    logic        wr_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m [32];
    logic [31:0] md [2];
    logic [1:0]  mv;
    logic        merr;
    int          busy_cnt;

    regfile_mp dut (
        .elk      (elk),
        .nrst     (nrst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .clr_req  (clr_req),
        .busy     (busy),
        .wr_err   (wr_err)
    );

    initial elk = 1'b0;
    always #5 elk = ~elk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 32; j++) m[j] = 32'h0;
        m[29]    = 32'd252;
        md[0]    = 32'h0;
        md[1]    = 32'h0;
        mv       = 2'b00;
        merr     = 1'b0;
        busy_cnt = 0;
    endtask

    task automatic idle_inputs();
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'h0;
        rd_en   = 2'b00;
        rd_addr = 10'd0;
        clr_req = 1'b0;
    endtask

    // Predict outputs from current inputs, clock once, compare against model.
    task automatic tick();
        logic [31:0] nd [2];
        logic [1:0]  nv;
        logic        nerr;
        logic        acc;
        logic [4:0]  a;
        nd[0] = md[0];
        nd[1] = md[1];
        nv    = 2'b00;
        nerr  = 1'b0;
        if (busy_cnt > 0) begin
            nerr = wr_en;
            busy_cnt--;
        end else begin
            acc  = wr_en && (wr_addr != 5'd0);
            nerr = wr_en && (wr_addr == 5'd0);
            for (int p = 0; p < 2; p++) begin
                if (rd_en[p]) begin
                    a     = rd_addr[p*5 +: 5];
                    nv[p] = 1'b1;
                    if (a == 5'd0)                        nd[p] = 32'h0;
                    else if (BYP && acc && a == wr_addr)  nd[p] = wr_data;
                    else                                  nd[p] = m[a];
                end
            end
            if (acc) m[wr_addr] = wr_data;
            if (clr_req) begin
                for (int j = 0; j < 32; j++) m[j] = 32'h0;
                m[29]    = 32'd252;
                busy_cnt = 31;
            end
        end
        md[0] = nd[0];
        md[1] = nd[1];
        mv    = nv;
        merr  = nerr;
        @(posedge elk);
        #1;
        chk("rd_data0", rd_data[31:0], md[0]);
        chk("rd_data1", rd_data[63:32], md[1]);
        chk("rd_valid", {30'd0, rd_valid}, {30'd0, mv});
        chk("busy", {31'd0, busy}, {31'd0, (busy_cnt > 0)});
        chk("wr_err", {31'd0, wr_err}, {31'd0, merr});
    endtask

    task automatic read_all(input bit expect_reset);
        for (int r = 0; r < 32; r += 2) begin
            idle_inputs();
            rd_en   = 2'b11;
            rd_addr = {5'(r + 1), 5'(r)};
            tick();
            if (expect_reset) begin
                chk("reset_val_even", rd_data[31:0], (r == 29) ? 32'd252 : 32'h0);
                chk("reset_val_odd", rd_data[63:32], (r + 1 == 29) ? 32'd252 : 32'h0);
            end
        end
    endtask

    typedef struct {
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ren;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic        ev0;
        logic        eerr;
    } vec_t;

    localparam logic [31:0] COLL = BYP ? 32'hA5A5A5A5 : 32'h0;

    vec_t tbl [8];
    int   nbusy;

    initial begin
        tbl[0] = '{1'b0, 5'd0, 32'h0,        2'b11, 5'd29, 5'd0, 32'd252,      1'b1, 1'b0};
        tbl[1] = '{1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0,  5'd0, 32'd252,      1'b0, 1'b0};
        tbl[2] = '{1'b0, 5'd0, 32'h0,        2'b01, 5'd5,  5'd0, 32'hDEADBEEF, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 5'd0, 32'h1234,     2'b00, 5'd0,  5'd0, 32'hDEADBEEF, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 5'd0, 32'h0,        2'b01, 5'd0,  5'd0, 32'h0,        1'b1, 1'b0};
        tbl[5] = '{1'b1, 5'd7, 32'hA5A5A5A5, 2'b01, 5'd7,  5'd0, COLL,         1'b1, 1'b0};
        tbl[6] = '{1'b0, 5'd0, 32'h0,        2'b01, 5'd7,  5'd0, 32'hA5A5A5A5, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 5'd0, 32'h55,       2'b01, 5'd0,  5'd0, 32'h0,        1'b1, 1'b1};

        // Reset state
        idle_inputs();
        nrst = 1'b1;
        model_reset();
        repeat (2) @(posedge elk);
        #1;
        chk("rst_rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
        chk("rst_rd_valid", {30'd0, rd_valid}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_wr_err", {31'd0, wr_err}, 32'h0);
        nrst = 1'b0;
        read_all(1'b1);

        // Directed vectors
        for (int k = 0; k < 8; k++) begin
            idle_inputs();
            wr_en   = tbl[k].wen;
            wr_addr = tbl[k].wa;
            wr_data = tbl[k].wd;
            rd_en   = tbl[k].ren;
            rd_addr = {tbl[k].ra1, tbl[k].ra0};
            tick();
            chk("vec_rd_data0", rd_data[31:0], tbl[k].ed0);
            chk("vec_rd_valid0", {31'd0, rd_valid[0]}, {31'd0, tbl[k].ev0});
            chk("vec_wr_err", {31'd0, wr_err}, {31'd0, tbl[k].eerr});
        end
        idle_inputs();
        tick();
        chk("wr_err_one_cycle", {31'd0, wr_err}, 32'h0);

        // Fill, then clear with a write in the request cycle and activity while busy
        for (int r = 1; r < 32; r++) begin
            idle_inputs();
            wr_en   = 1'b1;
            wr_addr = 5'(r);
            wr_data = 32'hFFFFFFFF;
            tick();
        end
        idle_inputs();
        clr_req = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h77;
        tick();
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 40) begin
            idle_inputs();
            clr_req = (nbusy < 5);
            wr_en   = 1'b1;
            wr_addr = 5'(nbusy % 32);
            wr_data = 32'h12340000 + nbusy;
            rd_en   = 2'b11;
            rd_addr = {5'd29, 5'(nbusy % 32)};
            tick();
            nbusy++;
        end
        chk("clear_busy_cycles", nbusy, 32'd31);
        read_all(1'b1);

        // Reset mid-clear at sweep index 10
        for (int r = 1; r < 32; r++) begin
            idle_inputs();
            wr_en   = 1'b1;
            wr_addr = 5'(r);
            wr_data = 32'hC0DE0000 + r;
            tick();
        end
        idle_inputs();
        clr_req = 1'b1;
        tick();
        idle_inputs();
        repeat (9) tick();
        chk("busy_before_mid_reset", {31'd0, busy}, 32'h1);
        nrst = 1'b1;
        #1;
        chk("busy_mid_reset", {31'd0, busy}, 32'h0);
        chk("rd_valid_mid_reset", {30'd0, rd_valid}, 32'h0);
        #1;
        nrst = 1'b0;
        model_reset();
        read_all(1'b1);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            idle_inputs();
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            rd_en   = 2'($urandom_range(0, 3));
            rd_addr = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) rd_addr[4:0] = wr_addr;
            clr_req = ($urandom_range(0, 59) == 0);
            tick();
        end
        idle_inputs();
        repeat (32) tick();
        read_all(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
